// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg : shared AES types, constants, S-box and xtime helpers. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package aes_pkg;

  localparam int AES_NO_ROUNDS = 10;
  localparam int AES_KEY_LEN   = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Byte 0x00 sits in the most significant byte of the table.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_key_round.sv
// ---------------------------------------------------------------------------
// aes_key_round : combinational single AES-128 key-expansion round. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aes_key_round
  import aes_pkg::*;
(
  input  logic [127:0] prev_key,
  input  logic [7:0]   rcon,
  output logic [127:0] next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, temp;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = prev_key;
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sub
    assign sub[8*i +: 8] = sbox(rot[8*i +: 8]);
  end

  assign temp = sub ^ {rcon, 24'h000000};
  assign n0   = w0 ^ temp;
  assign n1   = w1 ^ n0;
  assign n2   = w2 ^ n1;
  assign n3   = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

endmodule

`default_nettype wire

// File: rtl/aes_key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// aes_key_sched_ctrl : iterative AES-128 key schedule with indexed round-key
// store; optional zeroize port under KEY_SCHED_ZEROIZE_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int KEY_LEN   = AES_KEY_LEN,
  parameter int DATA_W    = AES_KEY_LEN,
  parameter int NO_ROUNDS = AES_NO_ROUNDS
) (
  input  logic               clk,
  input  logic               reset,
`ifdef KEY_SCHED_ZEROIZE_EN
  input  logic               zeroize,
`endif
  input  logic               key_valid,
  output logic               key_ready,
  input  logic [KEY_LEN-1:0] cipher_key,
  output logic               busy,
  output logic               keys_valid,
  input  logic               rd_en,
  input  logic [3:0]         rd_idx,
  output logic [DATA_W-1:0]  rd_key,
  output logic               rd_valid,
  output logic               rd_err
);

  localparam logic [3:0] RND_LAST = 4'(NO_ROUNDS);

  state_t            state_q, state_d;
  logic [3:0]        rnd_q;
  logic [7:0]        rcon_q;
  logic [DATA_W-1:0] store [0:NO_ROUNDS];
  logic [DATA_W-1:0] round_key;
  logic              zap, load, rd_ok;

`ifdef KEY_SCHED_ZEROIZE_EN
  assign zap = zeroize;
`else
  assign zap = 1'b0;
`endif

  aes_key_round u_round (
    .prev_key (store[rnd_q - 4'd1]),
    .rcon     (rcon_q),
    .next_key (round_key)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    key_ready  = 1'b0;
    busy       = 1'b0;
    keys_valid = 1'b0;
    case (state_q)
      IDLE:   key_ready = 1'b1;
      EXPAND: begin
        busy = 1'b1;
        if (rnd_q == RND_LAST) state_d = DONE;
      end
      DONE: begin
        key_ready  = 1'b1;
        keys_valid = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Ready is masked while reset is held so nothing is offered into a reset.
    if (reset || zap) key_ready = 1'b0;
    load = key_valid && key_ready;
    if (load) state_d = EXPAND;
    if (zap)  state_d = IDLE;
  end

  assign rd_ok = rd_en && keys_valid && !zap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rnd_q    <= '0;
      rcon_q   <= '0;
      rd_key   <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      for (int i = 0; i <= NO_ROUNDS; i++) store[i] <= '0;
    end else begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      if (zap) begin
        rnd_q  <= '0;
        rcon_q <= '0;
        rd_key <= '0;
        for (int i = 0; i <= NO_ROUNDS; i++) store[i] <= '0;
      end else begin
        if (load) begin
          store[0] <= cipher_key;
          rnd_q    <= 4'd1;
          rcon_q   <= 8'h01;
        end else if (busy) begin
          store[rnd_q] <= round_key;
          rcon_q       <= xtime(rcon_q);
          if (rnd_q != RND_LAST) rnd_q <= rnd_q + 4'd1;
        end
        // Reads see the pre-edge store, so a coincident reload returns old keys.
        if (rd_ok) begin
          rd_valid <= 1'b1;
          if (rd_idx > RND_LAST) begin
            rd_key <= '0;
            rd_err <= 1'b1;
          end else begin
            rd_key <= store[rd_idx];
          end
        end
      end
    end
  end

endmodule

`default_nettype wire
